// File: rtl/mem_bus_master.sv
// mem_bus_master: MEM-stage load/store initiator turning EX/MEM access fields into a req/gnt/rvalid bus transaction
// Ports:
//   cpu_clk, cpu_rst         pipeline clock, asynchronous active-high reset
//   EX_MEM_valid/mem_rd/mem_wr/mem_size/alu_c/rD2   access fields latched in EX/MEM
//   mem_stall                holds IF..EX/MEM and bubbles MEM/WB while the access is in flight
//   Bus_addr, Bus_rdata      byte address and raw word read data towards MEM/WB
//   bus_err                  sticky misalignment/timeout flag
//   bus_req/we/addr/wstrb/wdata   registered request side of the data bus
//   bus_gnt, bus_rvalid, bus_rdata_in   slave grant, read-valid and read data
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        EX_MEM_valid,
    input  logic        EX_MEM_mem_rd,
    input  logic        EX_MEM_mem_wr,
    input  logic [1:0]  EX_MEM_mem_size,
    input  logic [31:0] EX_MEM_alu_c,
    input  logic [31:0] EX_MEM_rD2,
    output logic        mem_stall,
    output logic [31:0] Bus_addr,
    output logic [31:0] Bus_rdata,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata_in
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        wr_q;
    logic        mem_op;
    logic        misal;
    logic        expire;
    logic [3:0]  strb;
    logic [31:0] wdata;
    assign mem_op = EX_MEM_valid & (EX_MEM_mem_rd | EX_MEM_mem_wr);
    assign misal  = (EX_MEM_mem_size == 2'b01) ? EX_MEM_alu_c[0]
                  : EX_MEM_mem_size[1] & (|EX_MEM_alu_c[1:0]);
    // >= rather than ==: a grant on the final allowed REQ cycle gets exactly one WAIT cycle
    assign expire = cnt >= 8'(TIMEOUT_CYCLES - 1);
    assign strb   = !EX_MEM_mem_wr ? 4'b0000
                  : (EX_MEM_mem_size == 2'b00) ? 4'b0001 << EX_MEM_alu_c[1:0]
                  : (EX_MEM_mem_size == 2'b01) ? (EX_MEM_alu_c[1] ? 4'b1100 : 4'b0011)
                  : 4'b1111;
    assign wdata  = (EX_MEM_mem_size == 2'b00) ? {4{EX_MEM_rD2[7:0]}}
                  : (EX_MEM_mem_size == 2'b01) ? {2{EX_MEM_rD2[15:0]}}
                  : EX_MEM_rD2;
    assign mem_stall = (state == IDLE & mem_op) | state == REQ | state == WAIT;
    assign Bus_addr  = (state == DONE) ? addr_q : EX_MEM_alu_c;
    assign Bus_rdata = (state == DONE) ? rdata_q : 32'h0;
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    addr_q  <= EX_MEM_alu_c;
                    rdata_q <= '0;
                    wr_q    <= EX_MEM_mem_wr;
                    cnt     <= '0;
                    if (misal) begin
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= EX_MEM_mem_wr;
                        bus_addr  <= {EX_MEM_alu_c[31:2], 2'b00};
                        bus_wstrb <= strb;
                        bus_wdata <= wdata;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= wr_q ? DONE : WAIT;
                    end else if (expire) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus_rvalid) begin
                        rdata_q <= bus_rdata_in;
                        state   <= DONE;
                    end else if (expire) begin
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized and directed checks of mem_bus_master against a transaction-level model
module tb_mem_bus_master;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        EX_MEM_valid = 1'b0, EX_MEM_mem_rd = 1'b0, EX_MEM_mem_wr = 1'b0;
    logic [1:0]  EX_MEM_mem_size = 2'b00;
    logic [31:0] EX_MEM_alu_c = 32'h0, EX_MEM_rD2 = 32'h0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata_in = 32'h0;
    logic        mem_stall, bus_err, bus_req, bus_we;
    logic [31:0] Bus_addr, Bus_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        stall_t, err_t, req_t, we_t;
    logic [31:0] baddr_t, brdata_t, addr_t, wdata_t;
    logic [3:0]  wstrb_t;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        err_exp = 1'b0;

    mem_bus_master dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .EX_MEM_valid(EX_MEM_valid), .EX_MEM_mem_rd(EX_MEM_mem_rd),
        .EX_MEM_mem_wr(EX_MEM_mem_wr), .EX_MEM_mem_size(EX_MEM_mem_size), .EX_MEM_alu_c(EX_MEM_alu_c),
        .EX_MEM_rD2(EX_MEM_rD2), .mem_stall(mem_stall), .Bus_addr(Bus_addr), .Bus_rdata(Bus_rdata),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata_in(bus_rdata_in)
    );

    mem_bus_master #(.TIMEOUT_CYCLES(4)) dut_t (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .EX_MEM_valid(EX_MEM_valid), .EX_MEM_mem_rd(EX_MEM_mem_rd),
        .EX_MEM_mem_wr(EX_MEM_mem_wr), .EX_MEM_mem_size(EX_MEM_mem_size), .EX_MEM_alu_c(EX_MEM_alu_c),
        .EX_MEM_rD2(EX_MEM_rD2), .mem_stall(stall_t), .Bus_addr(baddr_t), .Bus_rdata(brdata_t),
        .bus_err(err_t), .bus_req(req_t), .bus_we(we_t), .bus_addr(addr_t), .bus_wstrb(wstrb_t),
        .bus_wdata(wdata_t), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata_in(bus_rdata_in)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        EX_MEM_valid = 1'b0; EX_MEM_mem_rd = 1'b0; EX_MEM_mem_wr = 1'b0;
        EX_MEM_alu_c = 32'h0; EX_MEM_rD2 = 32'h0; EX_MEM_mem_size = 2'b00;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #2;
        n_checks++;
        if ({mem_stall, bus_err, bus_req, bus_we, Bus_addr, Bus_rdata, bus_addr, bus_wstrb, bus_wdata} !== '0)
            begin n_fail++; $display("FAIL reset_main: got stall=%b err=%b req=%b we=%b Baddr=%h Brd=%h addr=%h strb=%b wd=%h want all 0",
                mem_stall, bus_err, bus_req, bus_we, Bus_addr, Bus_rdata, bus_addr, bus_wstrb, bus_wdata); end
        n_checks++;
        if ({stall_t, err_t, req_t, we_t, baddr_t, brdata_t, addr_t, wstrb_t, wdata_t} !== '0)
            begin n_fail++; $display("FAIL reset_t4: got stall=%b err=%b req=%b we=%b Baddr=%h Brd=%h addr=%h strb=%b wd=%h want all 0",
                stall_t, err_t, req_t, we_t, baddr_t, brdata_t, addr_t, wstrb_t, wdata_t); end
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        err_exp = 1'b0;
        tick();
    endtask

    // One access on the default-timeout instance; gd = REQ cycles before gnt, rd = cycles from gnt to rvalid
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdat, input int gd, input int rd);
        int nb, off, stall_n, req_n, since, exp_stall;
        logic misal, done;
        logic [3:0] e_strb;
        logic [31:0] e_wdata, e_rdata;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        misal = (off % nb) != 0;
        e_strb = 4'b0;
        e_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wr && i >= off && i < off + nb) e_strb[i] = 1'b1;
            e_wdata[8*i +: 8] = d[8*(i % nb) +: 8];
        end
        e_rdata = (wr || misal) ? 32'h0 : rdat;
        exp_stall = misal ? 1 : wr ? gd + 2 : gd + 2 + rd;
        err_exp = err_exp | misal;
        EX_MEM_valid = 1'b1; EX_MEM_mem_wr = wr;
        EX_MEM_mem_rd = !wr || ($urandom_range(0, 3) == 0);
        EX_MEM_mem_size = sz; EX_MEM_alu_c = a; EX_MEM_rD2 = d;
        bus_rdata_in = rdat; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        stall_n = 0; req_n = 0; since = -1; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (!mem_stall) done = 1'b1;
            else begin
                stall_n++;
                if (bus_req) begin
                    n_checks++;
                    if (bus_addr !== (a & ~32'd3) || bus_we !== wr || bus_wstrb !== e_strb || (wr && bus_wdata !== e_wdata)) begin
                        n_fail++;
                        $display("FAIL request_fields a=%h: got addr=%h we=%b strb=%b wd=%h want addr=%h we=%b strb=%b wd=%h",
                            a, bus_addr, bus_we, bus_wstrb, bus_wdata, a & ~32'd3, wr, e_strb, e_wdata);
                    end
                    bus_gnt = (req_n == gd);
                    req_n++;
                    if (bus_gnt) since = 0;
                end else bus_gnt = 1'b0;
                bus_rvalid = (since == rd);
                @(posedge cpu_clk);
                if (since >= 0) since++;
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL access_timeout a=%h: stall never dropped within 200 cycles", a); end
        n_checks++;
        if (stall_n != exp_stall || req_n != (misal ? 0 : gd + 1))
            begin n_fail++; $display("FAIL stall_len a=%h: got stall=%0d req=%0d want stall=%0d req=%0d",
                a, stall_n, req_n, exp_stall, misal ? 0 : gd + 1); end
        n_checks++;
        if (Bus_addr !== a || Bus_rdata !== e_rdata || bus_err !== err_exp || bus_req !== 1'b0)
            begin n_fail++; $display("FAIL done_outputs a=%h: got Baddr=%h Brd=%h err=%b req=%b want Baddr=%h Brd=%h err=%b req=0",
                a, Bus_addr, Bus_rdata, bus_err, bus_req, a, e_rdata, err_exp); end
        tick();
        idle_inputs();
    endtask

    task automatic test_store_word();
        do_access(1'b1, 2'd2, 32'h100, 32'hA5A5_1234, 32'h0, 0, 0);
    endtask

    task automatic test_store_byte();
        do_access(1'b1, 2'd0, 32'h103, 32'h0000_00EE, 32'h0, 0, 0);
        do_access(1'b1, 2'd1, 32'h0000_0412, 32'h1234_BEEF, 32'h0, 1, 0);
    endtask

    task automatic test_load_delayed();
        do_access(1'b0, 2'd1, 32'h202, 32'h0, 32'hCAFE_BABE, 3, 2);
        do_access(1'b0, 2'd2, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 0, 1);
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 2'd1, 32'h301, 32'h0, 32'hFFFF_FFFF, 0, 1);
        do_access(1'b1, 2'd3, 32'h0000_0506, 32'h7777_8888, 32'h0, 0, 0);
        do_access(1'b0, 2'd2, 32'h0000_0600, 32'h0, 32'h2468_ACE0, 1, 1);
    endtask

    task automatic test_timeout();
        int req_n;
        logic done;
        test_reset();
        EX_MEM_valid = 1'b1; EX_MEM_mem_wr = 1'b1; EX_MEM_mem_size = 2'd2;
        EX_MEM_alu_c = 32'h40; EX_MEM_rD2 = 32'h1111_2222;
        req_n = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!stall_t) done = 1'b1;
            else begin
                if (req_t) req_n++;
                @(posedge cpu_clk);
            end
        end
        n_checks++;
        if (!done || req_n != 4) begin n_fail++; $display("FAIL timeout_req_len: got done=%b req_cycles=%0d want done=1 req_cycles=4", done, req_n); end
        n_checks++;
        if (brdata_t !== 32'h0 || err_t !== 1'b1 || req_t !== 1'b0 || baddr_t !== 32'h40)
            begin n_fail++; $display("FAIL timeout_done: got Brd=%h err=%b req=%b Baddr=%h want Brd=0 err=1 req=0 Baddr=00000040",
                brdata_t, err_t, req_t, baddr_t); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic wr;
        logic [1:0] sz;
        logic [31:0] a;
        test_reset();
        for (int k = 0; k < 24; k++) begin
            wr = 1'(($urandom_range(0, 1)));
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 7) != 0)
                a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
            do_access(wr, sz, a, $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        EX_MEM_valid = 1'b1; EX_MEM_mem_rd = 1'b1; EX_MEM_mem_size = 2'd2; EX_MEM_alu_c = 32'h80;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_checks++;
        if (mem_stall !== 1'b1 || bus_req !== 1'b0)
            begin n_fail++; $display("FAIL in_wait: got stall=%b req=%b want stall=1 req=0", mem_stall, bus_req); end
        #2;
        cpu_rst = 1'b1;
        EX_MEM_valid = 1'b0; EX_MEM_mem_rd = 1'b0; EX_MEM_alu_c = 32'h0;
        #1;
        n_checks++;
        if ({mem_stall, bus_err, bus_req, bus_we, Bus_addr, Bus_rdata, bus_addr, bus_wstrb, bus_wdata} !== '0)
            begin n_fail++; $display("FAIL async_reset: got stall=%b req=%b addr=%h Brd=%h want all 0", mem_stall, bus_req, bus_addr, Bus_rdata); end
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        tick();
        bus_rvalid = 1'b1; bus_rdata_in = 32'hDEAD_BEEF;
        tick();
        bus_rvalid = 1'b0;
        n_checks++;
        if (mem_stall !== 1'b0 || bus_req !== 1'b0 || Bus_rdata !== 32'h0)
            begin n_fail++; $display("FAIL late_rvalid: got stall=%b req=%b Brd=%h want 0 0 0", mem_stall, bus_req, Bus_rdata); end
        EX_MEM_valid = 1'b1; EX_MEM_alu_c = 32'h1234;
        #1;
        n_checks++;
        if (mem_stall !== 1'b0 || Bus_addr !== 32'h1234)
            begin n_fail++; $display("FAIL nonmem_op: got stall=%b Baddr=%h want stall=0 Baddr=00001234", mem_stall, Bus_addr); end
        tick();
        n_checks++;
        if (mem_stall !== 1'b0 || bus_req !== 1'b0)
            begin n_fail++; $display("FAIL nonmem_next: got stall=%b req=%b want 0 0", mem_stall, bus_req); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_delayed();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Load/store bus initiator for the MEM stage of the pipelined miniLA CPU. It turns the memory-access fields latched in the EX/MEM register into a request/grant/response transaction on the data bus. It stalls the pipeline until the access completes, then presents the raw word read data and the byte address to the MEM/WB register. Sub-word load extension is not done here; WB performs it from the address low bits and the sign-extension op.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in REQ+WAIT before the access is aborted (range 2..255).
- cpu_clk  in  1  pipeline clock; all state changes on rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- EX_MEM_valid  in  1  MEM stage holds a real instruction.
- EX_MEM_mem_rd  in  1  instruction is a load.
- EX_MEM_mem_wr  in  1  instruction is a store.
- EX_MEM_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- EX_MEM_alu_c  in  32  effective byte address.
- EX_MEM_rD2  in  32  store data (value in low bits).
- mem_stall  out  1  hold IF..EX/MEM registers and bubble MEM/WB.
- Bus_addr  out  32  byte address to MEM/WB.
- Bus_rdata  out  32  raw aligned word read data to MEM/WB.
- bus_err  out  1  sticky error flag (misaligned or timeout).
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address ({addr[31:2],2'b00}).
- bus_wstrb  out  4  byte enables; 0000 on reads.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  slave accepts request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata_in  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE.
- A memory op is EX_MEM_valid & (mem_rd | mem_wr). If rd and wr are both set, the op is treated as a store.
- IDLE: when a memory op is present, latch the address, data, size and type. If aligned, go to REQ; if misaligned (half with addr[0]=1, word with addr[1:0]≠0), set bus_err, set rdata latch to 0 and go to DONE. Non-memory ops stay in IDLE.
- REQ: bus_req=1. On bus_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on bus_rvalid, latch bus_rdata_in and go to DONE.
- DONE: go to IDLE unconditionally.
- Timeout counter: cleared on IDLE exit and incremented each REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES without completion, go to DONE with rdata latch 0, set bus_err and drop bus_req.
- Store lanes:
  - byte: wstrb = 4'b0001<<addr[1:0], wdata = {4{rD2[7:0]}}.
  - half: wstrb = addr[1]?1100:0011, wdata = {2{rD2[15:0]}}.
  - word: wstrb = 1111, wdata = rD2.
- Loads always read the full word (wstrb 0000).
- Bus_addr/Bus_rdata:
  - In DONE: latched address and latched data (0 for stores).
  - Otherwise: Bus_addr = EX_MEM_alu_c and Bus_rdata = 0.
- bus_err is cleared only by cpu_rst.

## Timing
- Reset values: all latches 0, bus_req/bus_we/bus_err/mem_stall 0, bus_addr/bus_wstrb/bus_wdata 0, state IDLE, counter 0.
- bus_req, bus_we, bus_addr, bus_wstrb and bus_wdata are registered. They are stable from REQ entry until the gnt cycle, and are held constant while bus_gnt=0.
- mem_stall is combinational:
  - 1 in IDLE when a memory op is present.
  - 1 in REQ and WAIT.
  - 0 in DONE and for non-memory ops.
- MEM/WB samples Bus_rdata/Bus_addr at the rising edge ending DONE; the pipeline advances on that same edge.
- Minimum latency (gnt in first REQ cycle):
  - store: IDLE, REQ, DONE = 3 cycles.
  - load with rvalid on the cycle after gnt: 4 cycles.
- bus_rvalid is ignored outside WAIT. A bus_gnt arriving in the same cycle as a timeout is honoured (no timeout).
- An asynchronous reset mid-transaction drops bus_req immediately and abandons the access; a late bus_rvalid is ignored.

## Test plan
- Store word: addr 0x100, rD2 0xA5A5_1234, gnt on first REQ cycle. Required: bus_addr 0x100, wstrb 1111, wdata 0xA5A5_1234; stall high for 2 cycles; Bus_rdata 0 in DONE.
- Store byte at 0x103, rD2 0x0000_00EE. Required: bus_addr 0x100, wstrb 1000, wdata 0xEEEE_EEEE.
- Load at 0x202 with gnt delayed 3 cycles and rvalid 2 cycles after gnt (data 0xCAFEBABE). Required: request held stable throughout; DONE shows Bus_addr 0x202, Bus_rdata 0xCAFEBABE; stall deasserts only in DONE.
- Misaligned half load at 0x301. Required: no bus_req; bus_err=1; DONE with Bus_rdata 0; bus_err stays 1 for later accesses.
- Timeout with TIMEOUT_CYCLES=4 and gnt never asserted. Required: bus_req high 4 cycles then 0; DONE with rdata 0; bus_err=1.
- Reset asserted in WAIT, then rvalid pulsed. Required: all outputs return to 0 and state is IDLE immediately; the pulse is ignored; a back-to-back non-memory op produces no stall.
